// File: rtl/axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// axis_pkt_checker : AXI-Stream sink that folds each packet into XOR/sum/len
//                    and reports them with error flags on a valid/ready port.
// Revision: 1.0
// ============================================================================
module axis_pkt_checker #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int EXPECTED_WORDS       = 8,
    parameter int MAX_WORDS            = 16
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    output logic                              s00_axis_tready,
    input  logic                              s00_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   res_xor,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   res_sum,
    output logic [7:0]                        res_len,
    output logic                              res_err_len,
    output logic                              res_err_strb,
    output logic [15:0]                       pkt_count,
    output logic [15:0]                       err_count,
    output logic [3:0]                        led
);
    localparam int         W         = C_S_AXIS_TDATA_WIDTH;
    localparam logic [7:0] C_MAX_LEN = 8'(MAX_WORDS);
    localparam logic [7:0] C_EXP_LEN = 8'(EXPECTED_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [W-1:0] acc_xor_q, acc_xor_d;
    logic [W-1:0] acc_sum_q, acc_sum_d;
    logic [7:0]   acc_len_q, acc_len_d;
    logic         acc_strb_q, acc_strb_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] res_xor_q, res_xor_d;
    logic [W-1:0] res_sum_q, res_sum_d;
    logic [7:0]   res_len_q, res_len_d;
    logic         res_err_len_q, res_err_len_d;
    logic         res_err_strb_q, res_err_strb_d;
    logic [15:0]  pkt_count_q, pkt_count_d;
    logic [15:0]  err_count_q, err_count_d;
    logic [3:0]   led_q, led_d;
    logic         w_accept;
    logic         w_strb_bad;
    logic         w_load;

    // Ready and valid come purely from registered state.
    assign s00_axis_tready = (state_q != S_REPORT);
    assign res_valid       = (state_q == S_REPORT);
    assign w_accept        = s00_axis_tvalid && (state_q != S_REPORT);
    assign w_strb_bad      = (s00_axis_tstrb != '1);

    always_comb begin
        state_d        = state_q;
        acc_xor_d      = acc_xor_q;
        acc_sum_d      = acc_sum_q;
        acc_len_d      = acc_len_q;
        acc_strb_d     = acc_strb_q;
        ovf_d          = ovf_q;
        res_xor_d      = res_xor_q;
        res_sum_d      = res_sum_q;
        res_len_d      = res_len_q;
        res_err_len_d  = res_err_len_q;
        res_err_strb_d = res_err_strb_q;
        pkt_count_d    = pkt_count_q;
        err_count_d    = err_count_q;
        led_d          = led_q;
        w_load         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    acc_xor_d  = s00_axis_tdata;
                    acc_sum_d  = s00_axis_tdata;
                    acc_len_d  = 8'd1;
                    acc_strb_d = w_strb_bad;
                    ovf_d      = 1'b0;
                    if (s00_axis_tlast) begin
                        state_d = S_REPORT;
                        w_load  = 1'b1;
                    end else if (C_MAX_LEN == 8'd1) begin
                        ovf_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (w_accept) begin
                    acc_xor_d  = acc_xor_q ^ s00_axis_tdata;
                    acc_sum_d  = acc_sum_q + s00_axis_tdata;
                    acc_len_d  = acc_len_q + 8'd1;
                    acc_strb_d = acc_strb_q | w_strb_bad;
                    // A closing beat that lands exactly on the limit is not an overflow.
                    if (s00_axis_tlast) begin
                        state_d = S_REPORT;
                        w_load  = 1'b1;
                    end else if (acc_len_d == C_MAX_LEN) begin
                        ovf_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && s00_axis_tlast) begin
                    state_d = S_REPORT;
                    w_load  = 1'b1;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    pkt_count_d = pkt_count_q + 16'd1;
                    if ((res_err_len_q || res_err_strb_q) && (err_count_q != 16'hFFFF))
                        err_count_d = err_count_q + 16'd1;
                    led_d = {pkt_count_d[1:0], res_err_len_q | res_err_strb_q,
                             res_xor_q != '0};
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Results are snapshotted so they stay frozen while the next packet accumulates.
        if (w_load) begin
            res_xor_d      = acc_xor_d;
            res_sum_d      = acc_sum_d;
            res_len_d      = acc_len_d;
            res_err_len_d  = ovf_d || (acc_len_d != C_EXP_LEN);
            res_err_strb_d = acc_strb_d;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q        <= S_IDLE;
            acc_xor_q      <= '0;
            acc_sum_q      <= '0;
            acc_len_q      <= '0;
            acc_strb_q     <= 1'b0;
            ovf_q          <= 1'b0;
            res_xor_q      <= '0;
            res_sum_q      <= '0;
            res_len_q      <= '0;
            res_err_len_q  <= 1'b0;
            res_err_strb_q <= 1'b0;
            pkt_count_q    <= '0;
            err_count_q    <= '0;
            led_q          <= '0;
        end else begin
            state_q        <= state_d;
            acc_xor_q      <= acc_xor_d;
            acc_sum_q      <= acc_sum_d;
            acc_len_q      <= acc_len_d;
            acc_strb_q     <= acc_strb_d;
            ovf_q          <= ovf_d;
            res_xor_q      <= res_xor_d;
            res_sum_q      <= res_sum_d;
            res_len_q      <= res_len_d;
            res_err_len_q  <= res_err_len_d;
            res_err_strb_q <= res_err_strb_d;
            pkt_count_q    <= pkt_count_d;
            err_count_q    <= err_count_d;
            led_q          <= led_d;
        end
    end

    assign res_xor      = res_xor_q;
    assign res_sum      = res_sum_q;
    assign res_len      = res_len_q;
    assign res_err_len  = res_err_len_q;
    assign res_err_strb = res_err_strb_q;
    assign pkt_count    = pkt_count_q;
    assign err_count    = err_count_q;
    assign led          = led_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// tb_axis_pkt_checker : directed and randomised self-checking bench.
// Revision: 1.0
// ============================================================================
module tb_axis_pkt_checker;
    localparam int W   = 32;
    localparam int EXP = 8;
    localparam int MAX = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          tready;
    logic          tvalid;
    logic [W-1:0]  tdata;
    logic [W/8-1:0] tstrb;
    logic          tlast;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_xor;
    logic [W-1:0]  res_sum;
    logic [7:0]    res_len;
    logic          res_err_len;
    logic          res_err_strb;
    logic [15:0]   pkt_count;
    logic [15:0]   err_count;
    logic [3:0]    led;

    int checks   = 0;
    int failures = 0;

    axis_pkt_checker #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .EXPECTED_WORDS      (EXP),
        .MAX_WORDS           (MAX)
    ) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s00_axis_tready(tready),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tdata (tdata),
        .s00_axis_tstrb (tstrb),
        .s00_axis_tlast (tlast),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_xor        (res_xor),
        .res_sum        (res_sum),
        .res_len        (res_len),
        .res_err_len    (res_err_len),
        .res_err_strb   (res_err_strb),
        .pkt_count      (pkt_count),
        .err_count      (err_count),
        .led            (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [W/8-1:0] s, input logic l);
        int guard;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        tvalid = 1'b1;
        guard  = 0;
        while (tready !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (guard >= 50) begin
            chk("tready_timeout", {63'd0, tready}, 64'd1);
            finish_tb();
        end
        tick(1);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_res();
        int guard;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (guard >= 50) begin
            chk("res_valid_timeout", {63'd0, res_valid}, 64'd1);
            finish_tb();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tready"}, tready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_xor"}, res_xor, 0);
        chk({tag, "_res_sum"}, res_sum, 0);
        chk({tag, "_res_len"}, res_len, 0);
        chk({tag, "_errs"}, {res_err_len, res_err_strb}, 0);
        chk({tag, "_pkt_count"}, pkt_count, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_led"}, led, 0);
    endtask

    logic [W-1:0]   m_d, m_xor, m_sum;
    logic [W/8-1:0] m_s;
    logic [7:0]     m_len;
    logic           m_bad, m_err_len, m_last_err, m_last_nz;
    logic [15:0]    m_err_count;
    int             m_n;

    initial begin
        rst       = 1'b1;
        tvalid    = 1'b0;
        tdata     = '0;
        tstrb     = '0;
        tlast     = 1'b0;
        res_ready = 1'b0;
        tick(2);
        check_reset_state("reset");
        rst = 1'b0;
        tick(1);

        // Packet 1: 1..8 with a mid-packet tvalid stall
        for (int i = 1; i <= 8; i++) begin
            send_beat(W'(i), 4'hF, i == 8);
            if (i == 4) tick(3);
        end
        chk("p1_latency_valid", res_valid, 1);
        chk("p1_tready_report", tready, 0);
        chk("p1_xor", res_xor, 32'h8);
        chk("p1_sum", res_sum, 32'h24);
        chk("p1_len", res_len, 8);
        chk("p1_errs", {res_err_len, res_err_strb}, 0);
        handshake();
        chk("p1_valid_after_hs", res_valid, 0);
        chk("p1_xor_held", res_xor, 32'h8);
        chk("p1_pkt_count", pkt_count, 1);
        chk("p1_err_count", err_count, 0);
        chk("p1_led", led, 4'b0101);

        // Packet 2: 8 x A5A5A5A5
        for (int i = 1; i <= 8; i++) send_beat(32'hA5A5_A5A5, 4'hF, i == 8);
        chk("p2_xor", res_xor, 0);
        chk("p2_sum", res_sum, 32'h2D2D_2D28);
        chk("p2_err_len", res_err_len, 0);
        handshake();
        chk("p2_led", led, 4'b1000);

        // Packet 3: 20 beats, only the first 16 accumulate
        for (int i = 1; i <= 20; i++) send_beat(W'(i), 4'hF, i == 20);
        chk("p3_len", res_len, 16);
        chk("p3_xor", res_xor, 32'h10);
        chk("p3_sum", res_sum, 32'h88);
        chk("p3_errs", {res_err_len, res_err_strb}, 2'b10);
        handshake();
        chk("p3_err_count", err_count, 1);
        chk("p3_pkt_count", pkt_count, 3);
        chk("p3_led", led, 4'b1111);

        // Packet 4: exactly MAX beats with tlast on the last one
        for (int i = 1; i <= 16; i++) send_beat(W'(i), 4'hF, i == 16);
        chk("p4_latency_valid", res_valid, 1);
        chk("p4_len", res_len, 16);
        chk("p4_sum", res_sum, 32'h88);
        chk("p4_err_len", res_err_len, 1);
        handshake();
        chk("p4_err_count", err_count, 2);
        chk("p4_led", led, 4'b0011);

        // Packet 5: short packet, partial strobe, result backpressure
        send_beat(32'h11, 4'hF, 1'b0);
        send_beat(32'h22, 4'h7, 1'b0);
        send_beat(32'h33, 4'hF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("p5_hold_tready", tready, 0);
            chk("p5_hold_valid", res_valid, 1);
            chk("p5_hold_res", {res_xor, res_sum}, {32'h0, 32'h66});
            chk("p5_hold_len_errs", {res_len, res_err_len, res_err_strb}, {8'd3, 2'b11});
            tick(1);
        end
        handshake();
        chk("p5_pkt_count", pkt_count, 5);
        chk("p5_err_count", err_count, 3);
        chk("p5_led", led, 4'b0110);

        // Reset mid-packet, then a fresh packet
        for (int i = 0; i < 4; i++) send_beat(32'h100 + W'(i), 4'hF, 1'b0);
        rst = 1'b1;
        tick(1);
        check_reset_state("midrst");
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) send_beat(32'h10 + W'(i), 4'hF, i == 7);
        chk("p6_xor", res_xor, 0);
        chk("p6_sum", res_sum, 32'h9C);
        chk("p6_len", res_len, 8);
        chk("p6_errs", {res_err_len, res_err_strb}, 0);
        handshake();
        chk("p6_pkt_count", pkt_count, 1);
        chk("p6_led", led, 4'b0100);

        // Randomised traffic against a reference model
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        m_err_count = 16'd0;
        m_last_err  = 1'b0;
        m_last_nz   = 1'b0;
        for (int p = 0; p < 1000; p++) begin
            m_n   = $urandom_range(1, 20);
            m_xor = '0;
            m_sum = '0;
            m_len = 8'd0;
            m_bad = 1'b0;
            for (int b = 0; b < m_n; b++) begin
                m_d = $urandom;
                m_s = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                if (b < MAX) begin
                    m_xor = m_xor ^ m_d;
                    m_sum = m_sum + m_d;
                    m_len = m_len + 8'd1;
                    if (m_s != 4'hF) m_bad = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
                send_beat(m_d, m_s, b == m_n - 1);
            end
            m_err_len = (m_n > MAX) || (m_len != 8'(EXP));
            wait_res();
            tick($urandom_range(0, 3));
            chk("rnd_xor", res_xor, m_xor);
            chk("rnd_sum", res_sum, m_sum);
            chk("rnd_len", res_len, m_len);
            chk("rnd_err_len", res_err_len, m_err_len);
            chk("rnd_err_strb", res_err_strb, m_bad);
            if (m_err_len || m_bad) m_err_count = m_err_count + 16'd1;
            m_last_err = m_err_len || m_bad;
            m_last_nz  = (m_xor != '0);
            handshake();
        end
        chk("rnd_pkt_count", pkt_count, 16'd1000);
        chk("rnd_err_count", err_count, m_err_count);
        chk("rnd_led", led, {2'b00, m_last_err, m_last_nz});

        finish_tb();
    end
endmodule
`default_nettype wire
